// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : pipe_pkg
// Purpose : Shared types and control constants for the pipeline hazard logic.
// Rev     : 1.0
// ----------------------------------------------------------------------------
package pipe_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2
    } state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic exmem_hold;
    } hz_ctrl_t;

    // IF/ID loads this word on a flush; ID/EX loads all-zero control on a bubble.
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
    localparam logic [15:0] BUBBLE_CTRL = 16'h0000;

    localparam hz_ctrl_t CTRL_RESET  = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1,
                                         idex_bubble: 1'b1, exmem_hold: 1'b0};
    localparam hz_ctrl_t CTRL_RUN    = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                         idex_bubble: 1'b0, exmem_hold: 1'b0};
    // The flushed NOP still has to be written into IF/ID, so the write enable stays high.
    localparam hz_ctrl_t CTRL_FLUSH  = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
                                         idex_bubble: 1'b1, exmem_hold: 1'b0};
    localparam hz_ctrl_t CTRL_STALL  = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                         idex_bubble: 1'b1, exmem_hold: 1'b0};
    localparam hz_ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                         idex_bubble: 1'b0, exmem_hold: 1'b1};

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_compare.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : hazard_compare
// Purpose : Load-use register compare; $0 never matches.
// Rev     : 1.0
// ----------------------------------------------------------------------------
module hazard_compare
    import pipe_pkg::*;
(
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    output logic             load_use
);

    always_comb begin
        load_use = ex_mem_read && (ex_rt != '0) &&
                   ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : pipeline_hazard_ctrl
// Purpose : Load-use, branch-flush and memory-wait control around ID/EX.
// Rev     : 1.0
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int LOAD_DELAY = 1,
    parameter int TIMEOUT    = 255,
    parameter int TO_W       = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_branch_taken,
    input  logic             ex_jump,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_hold,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_count,
    output logic [1:0]       state
);

    localparam logic [TO_W-1:0]  C_CNT_ONE   = TO_W'(1);
    localparam logic [TO_W-1:0]  C_LD_LAST   = TO_W'(LOAD_DELAY - 1);
    localparam logic [TO_W-1:0]  C_TIMEOUT   = TO_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] C_STALL_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [TO_W-1:0]  cnt_q, cnt_d;
    logic             timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic             load_use;
    logic             mem_stall;
    hz_ctrl_t         ctrl;
    hz_ctrl_t         run_ctrl;
    state_e           run_next;
    logic [TO_W-1:0]  run_cnt;

    hazard_compare u_cmp (
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .load_use    (load_use)
    );

    assign mem_stall = mem_req && !mem_ready;

    // RUN decode with the memory freeze excluded; also used on the MEM_WAIT exit cycle.
    always_comb begin
        run_ctrl = CTRL_RUN;
        run_next = ST_RUN;
        run_cnt  = '0;
        if (ex_branch_taken || ex_jump) begin
            run_ctrl = CTRL_FLUSH;
        end else if (load_use) begin
            run_ctrl = CTRL_STALL;
            if (LOAD_DELAY > 1) begin
                run_next = ST_LOAD_STALL;
                run_cnt  = C_CNT_ONE;
            end
        end
    end

    always_comb begin
        ctrl          = run_ctrl;
        state_d       = run_next;
        cnt_d         = run_cnt;
        timeout_err_d = timeout_err_q;
        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    ctrl    = CTRL_FREEZE;
                    state_d = ST_MEM_WAIT;
                    cnt_d   = C_CNT_ONE;
                end
            end
            ST_LOAD_STALL: begin
                if (mem_stall) begin
                    ctrl    = CTRL_FREEZE;
                    state_d = ST_MEM_WAIT;
                    cnt_d   = C_CNT_ONE;
                end else begin
                    ctrl    = CTRL_STALL;
                    state_d = (cnt_q == C_LD_LAST) ? ST_RUN : ST_LOAD_STALL;
                    cnt_d   = (cnt_q == C_LD_LAST) ? '0 : cnt_q + C_CNT_ONE;
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_ready) begin
                    ctrl    = CTRL_FREEZE;
                    state_d = ST_MEM_WAIT;
                    cnt_d   = (&cnt_q) ? cnt_q : cnt_q + C_CNT_ONE;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase

        if ((state_d == ST_MEM_WAIT) && (cnt_d >= C_TIMEOUT)) begin
            timeout_err_d = 1'b1;
        end

        stall_count_d = stall_count_q;
        if (!ctrl.pc_write && !(&stall_count_q)) begin
            stall_count_d = stall_count_q + C_STALL_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
            stall_count_q <= stall_count_d;
        end
    end

    always_comb begin
        if (rst) begin
            {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold} = CTRL_RESET;
        end else begin
            {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold} = ctrl;
        end
    end

    assign timeout_err = timeout_err_q;
    assign stall_count = stall_count_q;
    assign state       = state_q;

endmodule
`default_nettype wire
